// File: rtl/miniscope_readout_if.sv
// Signal bundle between the miniscope readout sequencer, its controller, the RAM read port
// and the DMB stream. "master" is the sequencer side, "slave" is everything around it.
interface miniscope_readout_if #(
    parameter int RAM_ADRB  = 11,
    parameter int RAM_WIDTH = 8,
    parameter int MXTBINB   = 5
);
    logic                   rd_start;
    logic [RAM_ADRB-1:0]    rd_adr_first;
    logic [MXTBINB-1:0]     rd_tbins;
    logic [RAM_ADRB-1:0]    fifo_radr_mini;
    logic [RAM_WIDTH*2-1:0] fifo_rdata_mini;
    logic [1:0]             parity_err_mini;
    logic [15:0]            mini_dout;
    logic                   mini_dvalid;
    logic                   mini_dlast;
    logic                   rd_busy;
    logic [7:0]             mini_perr_cnt;
    logic                   rdout_sump;

    modport master (
        input  rd_start,
        input  rd_adr_first,
        input  rd_tbins,
        input  fifo_rdata_mini,
        input  parity_err_mini,
        output fifo_radr_mini,
        output mini_dout,
        output mini_dvalid,
        output mini_dlast,
        output rd_busy,
        output mini_perr_cnt,
        output rdout_sump
    );

    modport slave (
        output rd_start,
        output rd_adr_first,
        output rd_tbins,
        output fifo_rdata_mini,
        output parity_err_mini,
        input  fifo_radr_mini,
        input  mini_dout,
        input  mini_dvalid,
        input  mini_dlast,
        input  rd_busy,
        input  mini_perr_cnt,
        input  rdout_sump
    );
endinterface

// File: rtl/miniscope_readout.sv
// Miniscope FIFO RAM read sequencer: emits header, N RAM data words and a trailer on the DMB stream.
// Parity accumulation is built only when MINI_RDOUT_PARITY_EN is defined.
module miniscope_readout #(
    parameter int RAM_ADRB  = 11,
    parameter int RAM_WIDTH = 8,
    parameter int MXTBINB   = 5
) (
    input  logic                clock,
    input  logic                reset,
    miniscope_readout_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        TRL  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [RAM_ADRB-1:0]    radr_q, radr_d;
    logic [MXTBINB-1:0]     tbins_q, tbins_d;
    logic [MXTBINB-1:0]     tbinCnt_q, tbinCnt_d;
    logic [RAM_WIDTH*2-1:0] dout_q, dout_d;
    logic                   dvalid_q, dvalid_d;
    logic                   dlast_q, dlast_d;
    logic                   busy_q, busy_d;
    logic [1:0]             perrSticky_q, perrSticky_d;
    logic [7:0]             perrCnt_q, perrCnt_d;
    logic                   sump_q, sump_d;

    logic [15:0]            headerWord;
    logic [15:0]            trailerWord;

    assign headerWord  = {4'hB, 1'b0, tbins_q[4:0], 6'h00};
    assign trailerWord = {4'hE, 2'b00, perrSticky_q, 3'b000, tbinCnt_q[4:0]};

    // Outputs lag the state by one edge, so rd_busy stays high through the cycle
    // in which the trailer is on the bus even though the FSM is already back in IDLE.
    always_comb begin
        state_d      = state_q;
        radr_d       = radr_q;
        tbins_d      = tbins_q;
        tbinCnt_d    = tbinCnt_q;
        dout_d       = dout_q;
        dvalid_d     = 1'b0;
        dlast_d      = 1'b0;
        busy_d       = 1'b0;
        perrSticky_d = perrSticky_q;
        perrCnt_d    = perrCnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.rd_start) begin
                    state_d      = HDR;
                    radr_d       = bus.rd_adr_first;
                    tbins_d      = bus.rd_tbins;
                    tbinCnt_d    = '0;
                    busy_d       = 1'b1;
                    perrSticky_d = 2'b00;
                end
            end

            HDR: begin
                dout_d   = headerWord;
                dvalid_d = 1'b1;
                busy_d   = 1'b1;
                radr_d   = radr_q + RAM_ADRB'(1);
                state_d  = (tbins_q != '0) ? DATA : TRL;
            end

            DATA: begin
                dout_d    = bus.fifo_rdata_mini;
                dvalid_d  = 1'b1;
                busy_d    = 1'b1;
                radr_d    = radr_q + RAM_ADRB'(1);
                tbinCnt_d = tbinCnt_q + MXTBINB'(1);
`ifdef MINI_RDOUT_PARITY_EN
                perrSticky_d = perrSticky_q | bus.parity_err_mini;
                if ((|bus.parity_err_mini) && (perrCnt_q != 8'hFF)) begin
                    perrCnt_d = perrCnt_q + 8'd1;
                end
`endif
                if (tbinCnt_q == (tbins_q - MXTBINB'(1))) begin
                    state_d = TRL;
                end
            end

            TRL: begin
                dout_d   = trailerWord;
                dvalid_d = 1'b1;
                dlast_d  = 1'b1;
                busy_d   = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Without the parity feature the flags are otherwise unused and only feed the sump.
    always_comb begin
`ifdef MINI_RDOUT_PARITY_EN
        sump_d = 1'b0;
`else
        sump_d = |bus.parity_err_mini;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            radr_q       <= '0;
            tbins_q      <= '0;
            tbinCnt_q    <= '0;
            dout_q       <= '0;
            dvalid_q     <= 1'b0;
            dlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            perrSticky_q <= 2'b00;
            perrCnt_q    <= 8'h00;
            sump_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            radr_q       <= radr_d;
            tbins_q      <= tbins_d;
            tbinCnt_q    <= tbinCnt_d;
            dout_q       <= dout_d;
            dvalid_q     <= dvalid_d;
            dlast_q      <= dlast_d;
            busy_q       <= busy_d;
            perrSticky_q <= perrSticky_d;
            perrCnt_q    <= perrCnt_d;
            sump_q       <= sump_d;
        end
    end

    assign bus.fifo_radr_mini = radr_q;
    assign bus.mini_dout      = dout_q;
    assign bus.mini_dvalid    = dvalid_q;
    assign bus.mini_dlast     = dlast_q;
    assign bus.rd_busy        = busy_q;
    assign bus.mini_perr_cnt  = perrCnt_q;
    assign bus.rdout_sump     = sump_q;

endmodule

// File: tb/tb_miniscope_readout.sv
// Directed self-checking bench for miniscope_readout; RAM model returns data == address.
// Parity expectations follow MINI_RDOUT_PARITY_EN.
`timescale 1ns/1ps
module tb_miniscope_readout;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] gotWord[$];
    logic        gotLast[$];
    int          firstValid;
    int          gaps;
    bit          timedOut;

`ifdef MINI_RDOUT_PARITY_EN
    localparam logic [15:0] PerrTrailer = 16'hE205;
    localparam logic [7:0]  PerrCount   = 8'd1;
`else
    localparam logic [15:0] PerrTrailer = 16'hE005;
    localparam logic [7:0]  PerrCount   = 8'd0;
`endif

    miniscope_readout_if #(.RAM_ADRB(11), .RAM_WIDTH(8), .MXTBINB(5)) bus ();

    miniscope_readout #(.RAM_ADRB(11), .RAM_WIDTH(8), .MXTBINB(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus.fifo_rdata_mini <= 16'(bus.fifo_radr_mini);
    end

    // Caller sits on a negedge; rd_start is taken at the following posedge (E0).
    task automatic applyStimulus(input logic [10:0] first, input logic [4:0] tbins);
        bus.rd_adr_first = first;
        bus.rd_tbins     = tbins;
        bus.rd_start     = 1'b1;
        @(negedge clock);
        bus.rd_start     = 1'b0;
    endtask

    // Cycle 0 is the negedge after E0; stops on the negedge showing mini_dlast.
    task automatic collectWords(input int pokeCycle, input int perrCycle);
        bit started = 0;
        bit done = 0;
        gotWord.delete();
        gotLast.delete();
        firstValid = -1;
        gaps       = 0;
        timedOut   = 1;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            bus.rd_start = (cyc == pokeCycle);
            if (cyc == pokeCycle) begin
                bus.rd_adr_first = 11'h300;
                bus.rd_tbins     = 5'd2;
            end
            bus.parity_err_mini = (cyc == perrCycle) ? 2'b10 : 2'b00;
            if (bus.mini_dvalid) begin
                gotWord.push_back(bus.mini_dout);
                gotLast.push_back(bus.mini_dlast);
                if (!started) firstValid = cyc;
                started = 1;
                if (bus.mini_dlast) begin
                    done     = 1;
                    timedOut = 0;
                end
            end else if (started) begin
                gaps++;
            end
            if (!done) @(negedge clock);
        end
        bus.rd_start        = 1'b0;
        bus.parity_err_mini = 2'b00;
    endtask

    task automatic test_reset();
        reset               = 1'b1;
        bus.rd_start        = 1'b0;
        bus.rd_adr_first    = '0;
        bus.rd_tbins        = '0;
        bus.parity_err_mini = 2'b00;
        repeat (3) @(negedge clock);
        checks++; if (bus.fifo_radr_mini !== 11'h000) begin errors++; $display("[TB] FAIL reset_radr: got %h expected 000", bus.fifo_radr_mini); end
        checks++; if (bus.mini_dout !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 0000", bus.mini_dout); end
        checks++; if (bus.mini_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid: got %b expected 0", bus.mini_dvalid); end
        checks++; if (bus.mini_dlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_dlast: got %b expected 0", bus.mini_dlast); end
        checks++; if (bus.rd_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.rd_busy); end
        checks++; if (bus.mini_perr_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_perrcnt: got %h expected 00", bus.mini_perr_cnt); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (bus.rd_busy !== 1'b0 || bus.mini_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy %b dvalid %b expected 0 0", bus.rd_busy, bus.mini_dvalid); end
    endtask

    task automatic test_basic();
        logic [15:0] exp[$];
        exp.push_back(16'hB1C0);
        for (int i = 0; i < 7; i++) exp.push_back(16'h0010 + 16'(i));
        exp.push_back(16'hE007);
        applyStimulus(11'h010, 5'd7);
        checks++; if (bus.rd_busy !== 1'b1 || bus.fifo_radr_mini !== 11'h010) begin errors++; $display("[TB] FAIL basic_e0: busy %b radr %h expected 1 010", bus.rd_busy, bus.fifo_radr_mini); end
        collectWords(-1, -1);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL basic_timeout: no trailer seen, expected trailer within 80 cycles"); end
        checks++; if (firstValid !== 1) begin errors++; $display("[TB] FAIL basic_latency: header at cycle %0d expected 1", firstValid); end
        checks++; if (gotWord.size() !== 9 || gaps !== 0) begin errors++; $display("[TB] FAIL basic_count: %0d words %0d gaps expected 9 words 0 gaps", gotWord.size(), gaps); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= gotWord.size()) begin errors++; $display("[TB] FAIL basic_word%0d: missing, expected %h", i, exp[i]); end
            else if (gotWord[i] !== exp[i] || gotLast[i] !== (i == exp.size() - 1)) begin errors++; $display("[TB] FAIL basic_word%0d: got %h last %b expected %h last %b", i, gotWord[i], gotLast[i], exp[i], i == exp.size() - 1); end
        end
        checks++; if (bus.rd_busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_trl: got %b expected 1", bus.rd_busy); end
        @(negedge clock);
        checks++; if (bus.rd_busy !== 1'b0 || bus.mini_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_end: busy %b dvalid %b expected 0 0", bus.rd_busy, bus.mini_dvalid); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp[$];
        exp = {16'hB100, 16'h07FE, 16'h07FF, 16'h0000, 16'h0001, 16'hE004};
        applyStimulus(11'h7FE, 5'd4);
        collectWords(-1, -1);
        checks++; if (timedOut || gotWord.size() !== 6) begin errors++; $display("[TB] FAIL wrap_count: %0d words timeout %b expected 6 words", gotWord.size(), timedOut); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= gotWord.size()) begin errors++; $display("[TB] FAIL wrap_word%0d: missing, expected %h", i, exp[i]); end
            else if (gotWord[i] !== exp[i]) begin errors++; $display("[TB] FAIL wrap_word%0d: got %h expected %h", i, gotWord[i], exp[i]); end
        end
        @(negedge clock);
    endtask

    task automatic test_zero_tbins();
        applyStimulus(11'h055, 5'd0);
        collectWords(-1, -1);
        checks++; if (timedOut || gotWord.size() !== 2 || firstValid !== 1) begin errors++; $display("[TB] FAIL zero_count: %0d words first %0d expected 2 words first 1", gotWord.size(), firstValid); end
        if (gotWord.size() == 2) begin
            checks++; if (gotWord[0] !== 16'hB000 || gotLast[0] !== 1'b0) begin errors++; $display("[TB] FAIL zero_header: got %h last %b expected B000 last 0", gotWord[0], gotLast[0]); end
            checks++; if (gotWord[1] !== 16'hE000 || gotLast[1] !== 1'b1) begin errors++; $display("[TB] FAIL zero_trailer: got %h last %b expected E000 last 1", gotWord[1], gotLast[1]); end
        end
        @(negedge clock);
    endtask

    task automatic test_parity();
        logic [15:0] exp[$];
        exp = {16'hB140, 16'h0030, 16'h0031, 16'h0032, 16'h0033, 16'h0034, PerrTrailer};
        applyStimulus(11'h030, 5'd5);
        collectWords(-1, 3);
        checks++; if (timedOut || gotWord.size() !== 7) begin errors++; $display("[TB] FAIL parity_count: %0d words expected 7", gotWord.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= gotWord.size()) begin errors++; $display("[TB] FAIL parity_word%0d: missing, expected %h", i, exp[i]); end
            else if (gotWord[i] !== exp[i]) begin errors++; $display("[TB] FAIL parity_word%0d: got %h expected %h", i, gotWord[i], exp[i]); end
        end
        @(negedge clock);
        checks++; if (bus.mini_perr_cnt !== PerrCount) begin errors++; $display("[TB] FAIL parity_cnt: got %0d expected %0d", bus.mini_perr_cnt, PerrCount); end
        // Flag during the header edge: not sampled, and the sticky bits from the last run are cleared.
        applyStimulus(11'h030, 5'd5);
        collectWords(-1, 0);
        checks++; if (gotWord.size() !== 7 || gotWord[gotWord.size()-1] !== 16'hE005) begin errors++; $display("[TB] FAIL parity_hdr_trailer: got %h (%0d words) expected E005", gotWord.size() > 0 ? gotWord[gotWord.size()-1] : 16'h0, gotWord.size()); end
        @(negedge clock);
        checks++; if (bus.mini_perr_cnt !== PerrCount) begin errors++; $display("[TB] FAIL parity_hdr_cnt: got %0d expected %0d", bus.mini_perr_cnt, PerrCount); end
        applyStimulus(11'h030, 5'd5);
        collectWords(-1, 6);
        @(negedge clock);
        checks++; if (bus.mini_perr_cnt !== PerrCount) begin errors++; $display("[TB] FAIL parity_trl_cnt: got %0d expected %0d", bus.mini_perr_cnt, PerrCount); end
    endtask

    task automatic test_start_ignored();
        logic [15:0] exp[$];
        exp = {16'hB180, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'hE006};
        applyStimulus(11'h100, 5'd6);
        collectWords(3, -1);
        checks++; if (timedOut || gotWord.size() !== 8 || gaps !== 0) begin errors++; $display("[TB] FAIL ignore_count: %0d words %0d gaps expected 8 words 0 gaps", gotWord.size(), gaps); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= gotWord.size()) begin errors++; $display("[TB] FAIL ignore_word%0d: missing, expected %h", i, exp[i]); end
            else if (gotWord[i] !== exp[i]) begin errors++; $display("[TB] FAIL ignore_word%0d: got %h expected %h", i, gotWord[i], exp[i]); end
        end
        repeat (3) @(negedge clock);
        checks++; if (bus.rd_busy !== 1'b0 || bus.mini_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL ignore_idle: busy %b dvalid %b expected 0 0", bus.rd_busy, bus.mini_dvalid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp[$];
        applyStimulus(11'h020, 5'd2);
        collectWords(-1, -1);
        checks++; if (gotWord.size() !== 4 || gotWord[0] !== 16'hB080 || gotWord[3] !== 16'hE002) begin errors++; $display("[TB] FAIL b2b_first: %0d words expected 4 words B080..E002", gotWord.size()); end
        applyStimulus(11'h040, 5'd1);
        checks++; if (bus.rd_busy !== 1'b1 || bus.mini_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: busy %b dvalid %b expected 1 0", bus.rd_busy, bus.mini_dvalid); end
        exp = {16'hB040, 16'h0040, 16'hE001};
        collectWords(-1, -1);
        checks++; if (timedOut || firstValid !== 1 || gotWord.size() !== 3) begin errors++; $display("[TB] FAIL b2b_second: %0d words first %0d expected 3 words first 1", gotWord.size(), firstValid); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= gotWord.size()) begin errors++; $display("[TB] FAIL b2b_word%0d: missing, expected %h", i, exp[i]); end
            else if (gotWord[i] !== exp[i]) begin errors++; $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, gotWord[i], exp[i]); end
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midread();
        int strayValid = 0;
        applyStimulus(11'h200, 5'd6);
        repeat (3) @(negedge clock);
        checks++; if (bus.mini_dvalid !== 1'b1 || bus.mini_dout !== 16'h0201) begin errors++; $display("[TB] FAIL midreset_pre: dvalid %b dout %h expected 1 0201", bus.mini_dvalid, bus.mini_dout); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mini_dvalid !== 1'b0 || bus.rd_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: dvalid %b busy %b expected 0 0", bus.mini_dvalid, bus.rd_busy); end
        checks++; if (bus.fifo_radr_mini !== 11'h000 || bus.mini_perr_cnt !== 8'h00) begin errors++; $display("[TB] FAIL midreset_regs: radr %h perrcnt %h expected 000 00", bus.fifo_radr_mini, bus.mini_perr_cnt); end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.mini_dvalid || bus.rd_busy) strayValid++;
        end
        checks++; if (strayValid !== 0) begin errors++; $display("[TB] FAIL midreset_no_trailer: %0d active cycles expected 0", strayValid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_tbins();
        test_parity();
        test_start_ignored();
        test_back_to_back();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
